// File: rtl/cdb_arbiter.sv
// Round-robin arbiter between the functional-unit completion ports and the
// common data bus: combinational ack to one done FU, registered broadcast one cycle later.

`ifndef XLEN
`define XLEN 32
`endif

module cdb_arbiter #(
  parameter  int N_FU      = 4,
  parameter  int ROB_TAG_W = 5,
  localparam int PTR_W     = $clog2(N_FU)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      squash,
  input  logic [N_FU-1:0]           fu_done,
  input  logic [N_FU*`XLEN-1:0]     fu_value,
  input  logic [N_FU*ROB_TAG_W-1:0] fu_rob_tag,
  input  logic [N_FU-1:0]           fu_take_branch,
  output logic [N_FU-1:0]           ack,
  output logic                      cdb_valid,
  output logic [`XLEN-1:0]          cdb_value,
  output logic [ROB_TAG_W-1:0]      cdb_rob_tag,
  output logic                      cdb_take_branch,
  output logic [15:0]               grant_count
);

  logic [`XLEN-1:0]     value_arr [N_FU];
  logic [ROB_TAG_W-1:0] tag_arr   [N_FU];

  for (genvar g = 0; g < N_FU; g++) begin : g_unpack
    assign value_arr[g] = fu_value[g*`XLEN +: `XLEN];
    assign tag_arr[g]   = fu_rob_tag[g*ROB_TAG_W +: ROB_TAG_W];
  end

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W-1:0] next_ptr;
  logic [PTR_W-1:0] scan_idx;
  logic             grant_valid;
  int               scan;

  // Scan from rr_ptr upward with wrap; the first done FU wins.
  always_comb begin
    // NOTE: every output of this block gets a default before any branch, so no latch is inferred.
    ack         = '0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan        = 0;
    scan_idx    = '0;
    if (!reset && !squash) begin
      for (int k = 0; k < N_FU; k++) begin
        scan = int'(rr_ptr) + k;
        if (scan >= N_FU) scan = scan - N_FU;
        scan_idx = PTR_W'(scan);
        if (!grant_valid && fu_done[scan_idx]) begin
          grant_valid = 1'b1;
          grant_idx   = scan_idx;
        end
      end
    end
    if (grant_valid) ack[grant_idx] = 1'b1;
  end

  assign next_ptr = (grant_idx == PTR_W'(N_FU - 1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cdb_valid       <= 1'b0;
      cdb_value       <= '0;
      cdb_rob_tag     <= '0;
      cdb_take_branch <= 1'b0;
      grant_count     <= '0;
      rr_ptr          <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      cdb_valid <= grant_valid;
      if (grant_valid) begin
        cdb_value       <= value_arr[grant_idx];
        cdb_rob_tag     <= tag_arr[grant_idx];
        cdb_take_branch <= fu_take_branch[grant_idx];
        rr_ptr          <= next_ptr;
        if (grant_count != 16'hFFFF) grant_count <= grant_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a rotation-order model predicts ack each cycle and
// queues the expected broadcast, which an independent monitor compares when cdb_valid rises.

`ifndef XLEN
`define XLEN 32
`endif

module tb_cdb_arbiter;
  localparam int N_FU      = 4;
  localparam int ROB_TAG_W = 5;
  localparam int XL        = `XLEN;

  logic                      clock = 1'b0;
  logic                      reset;
  logic                      squash;
  logic [N_FU-1:0]           fu_done;
  logic [N_FU*XL-1:0]        fu_value;
  logic [N_FU*ROB_TAG_W-1:0] fu_rob_tag;
  logic [N_FU-1:0]           fu_take_branch;
  logic [N_FU-1:0]           ack;
  logic                      cdb_valid;
  logic [XL-1:0]             cdb_value;
  logic [ROB_TAG_W-1:0]      cdb_rob_tag;
  logic                      cdb_take_branch;
  logic [15:0]               grant_count;

  cdb_arbiter #(.N_FU(N_FU), .ROB_TAG_W(ROB_TAG_W)) dut (
    .clock          (clock),
    .reset          (reset),
    .squash         (squash),
    .fu_done        (fu_done),
    .fu_value       (fu_value),
    .fu_rob_tag     (fu_rob_tag),
    .fu_take_branch (fu_take_branch),
    .ack            (ack),
    .cdb_valid      (cdb_valid),
    .cdb_value      (cdb_value),
    .cdb_rob_tag    (cdb_rob_tag),
    .cdb_take_branch(cdb_take_branch),
    .grant_count    (grant_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [XL-1:0]        value;
    logic [ROB_TAG_W-1:0] tag;
    logic                 br;
    int                   count;
  } pkt_t;

  pkt_t sb[$];
  pkt_t mon_pkt;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   m_ptr    = 0;
  int   m_count  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: the winner is the first done FU in rotation order starting at the pointer.
  function automatic int model_winner(input logic [N_FU-1:0] done, input logic sq);
    if (sq) return -1;
    for (int k = 0; k < N_FU; k++) begin
      int i = (m_ptr + k) % N_FU;
      if (done[i]) return i;
    end
    return -1;
  endfunction

  task automatic set_fu(input int i, input logic [XL-1:0] v, input logic [ROB_TAG_W-1:0] t,
                        input logic b);
    fu_value[i*XL +: XL]                 = v;
    fu_rob_tag[i*ROB_TAG_W +: ROB_TAG_W] = t;
    fu_take_branch[i]                    = b;
  endtask

  // Called at posedge+1; drives one cycle and returns at the following posedge+1.
  task automatic cycle(input logic [N_FU-1:0] done, input logic sq);
    int              w;
    pkt_t            p;
    logic [N_FU-1:0] exp_ack;
    fu_done = done;
    squash  = sq;
    w       = model_winner(done, sq);
    exp_ack = '0;
    if (w >= 0) exp_ack[w] = 1'b1;
    @(negedge clock);
    check("ack", 64'(ack), 64'(exp_ack));
    @(posedge clock);
    if (w >= 0) begin
      p.value = fu_value[w*XL +: XL];
      p.tag   = fu_rob_tag[w*ROB_TAG_W +: ROB_TAG_W];
      p.br    = fu_take_branch[w];
      m_count = (m_count == 65535) ? 65535 : m_count + 1;
      p.count = m_count;
      sb.push_back(p);
      m_ptr = (w + 1) % N_FU;
    end
    #1;
  endtask

  task automatic apply_reset();
    fu_done = '1;
    squash  = 1'b0;
    reset   = 1'b1;
    #1;
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_cdb_valid", 64'(cdb_valid), 64'd0);
    check("rst_grant_count", 64'(grant_count), 64'd0);
    fu_done = '0;
    @(posedge clock);
    #1;
    reset   = 1'b0;
    m_ptr   = 0;
    m_count = 0;
    sb.delete();
  endtask

  // Monitor: every broadcast must match the oldest queued expectation.
  initial begin
    forever begin
      @(negedge clock);
      if (reset === 1'b0 && cdb_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("cdb_unexpected_valid", 64'(cdb_valid), 64'd0);
        end else begin
          mon_pkt = sb.pop_front();
          check("cdb_value", 64'(cdb_value), 64'(mon_pkt.value));
          check("cdb_rob_tag", 64'(cdb_rob_tag), 64'(mon_pkt.tag));
          check("cdb_take_branch", 64'(cdb_take_branch), 64'(mon_pkt.br));
          check("grant_count", 64'(grant_count), 64'(mon_pkt.count));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b0;
    squash         = 1'b0;
    fu_done        = '0;
    fu_value       = '0;
    fu_rob_tag     = '0;
    fu_take_branch = '0;
    #1;
    apply_reset();

    // Idle after reset.
    repeat (3) begin
      cycle(4'b0000, 1'b0);
      check("idle_cdb_valid", 64'(cdb_valid), 64'd0);
      check("idle_grant_count", 64'(grant_count), 64'd0);
    end

    // Single FU 2 completion, pointer moves to 3.
    set_fu(2, 32'h0000_00AA, 5'd7, 1'b1);
    cycle(4'b0100, 1'b0);
    check("d_cdb_valid", 64'(cdb_valid), 64'd1);
    check("d_cdb_value", 64'(cdb_value), 64'h0000_00AA);
    check("d_cdb_rob_tag", 64'(cdb_rob_tag), 64'd7);
    check("d_cdb_take_branch", 64'(cdb_take_branch), 64'd1);
    check("d_grant_count", 64'(grant_count), 64'd1);

    // Pointer at 3 wraps to FU 0, then moves on to FU 1.
    set_fu(0, 32'h1111_0000, 5'd10, 1'b0);
    set_fu(1, 32'h2222_0000, 5'd11, 1'b1);
    cycle(4'b0011, 1'b0);
    cycle(4'b0011, 1'b0);

    // Squash blocks the grant and leaves the pointer and count alone.
    cycle(4'b0010, 1'b1);
    check("sq_cdb_valid", 64'(cdb_valid), 64'd0);
    check("sq_grant_count", 64'(grant_count), 64'(m_count));
    cycle(4'b0010, 1'b0);

    // Fairness with every FU continuously done.
    apply_reset();
    for (int i = 0; i < N_FU; i++) set_fu(i, $urandom, ROB_TAG_W'(i), i[0]);
    repeat (8) cycle(4'b1111, 1'b0);

    // Asynchronous reset while a broadcast is on the bus.
    set_fu(2, 32'hDEAD_BEEF, 5'd21, 1'b0);
    cycle(4'b0100, 1'b0);
    check("pre_rst_cdb_valid", 64'(cdb_valid), 64'd1);
    #5;
    fu_done = 4'b1010;
    #1 reset = 1'b1;
    #1;
    check("async_cdb_valid", 64'(cdb_valid), 64'd0);
    check("async_ack", 64'(ack), 64'd0);
    check("async_grant_count", 64'(grant_count), 64'd0);
    fu_done = '0;
    #1 reset = 1'b0;
    m_ptr   = 0;
    m_count = 0;
    sb.delete();
    @(posedge clock);
    #1;
    cycle(4'b1010, 1'b0);

    // Randomized traffic.
    repeat (300) begin
      for (int i = 0; i < N_FU; i++) set_fu(i, $urandom, ROB_TAG_W'($urandom), 1'($urandom));
      cycle(N_FU'($urandom), ($urandom_range(0, 9) == 0));
    end

    cycle(4'b0000, 1'b0);
    cycle(4'b0000, 1'b0);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Consumer end of the FU completion handshake.
- Each functional unit holds a done flag plus a result (value, rob_tag, take_branch) until it sees ack.
- This block picks one done FU per cycle (round-robin), returns ack to that FU, and broadcasts the selected result on the CDB one cycle later.
- It sits between the FU array and the CDB consumers: ROB, reservation stations and map table.

Parameters:
- N_FU, 4, number of FU completion ports (>=2).
- ROB_TAG_W, 5, width of rob_tag.
- PTR_W, $clog2(N_FU), width of the round-robin pointer (derived, not overridden).

Ports:
- clock  in  1  system clock, all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- squash  in  1  pipeline flush; suppresses grant and broadcast.
- fu_done  in  N_FU  per-FU result-pending flag.
- fu_value  in  N_FU*`XLEN  per-FU result; FU i occupies bits [i*`XLEN +: `XLEN].
- fu_rob_tag  in  N_FU*ROB_TAG_W  per-FU ROB tag, same packing.
- fu_take_branch  in  N_FU  per-FU branch-taken flag.
- ack  out  N_FU  one-hot (or zero) grant; combinational; FU i clears done at the next posedge.
- cdb_valid  out  1  registered; broadcast valid this cycle.
- cdb_value  out  `XLEN  registered broadcast value.
- cdb_rob_tag  out  ROB_TAG_W  registered broadcast tag.
- cdb_take_branch  out  1  registered broadcast branch flag.
- grant_count  out  16  registered count of completed broadcasts, saturating.

Behaviour:
- Reset (async, active-high):
  - cdb_valid, cdb_value, cdb_rob_tag, cdb_take_branch, grant_count, rr_ptr all <= 0 immediately, without waiting for a clock edge.
  - ack forced to 0 combinationally while reset is high.
- Grant (combinational):
  - Scan FUs in order rr_ptr, rr_ptr+1, ..., N_FU-1, 0, ..., rr_ptr-1.
  - The first i with fu_done[i]=1 wins; ack[i]=1, all other ack bits 0.
  - No FU done -> ack=0.
  - squash=1 -> ack=0 regardless of fu_done.
- Handshake contract:
  - ack[i] high at posedge means the packet FU i presents in that cycle is consumed.
  - The FU deasserts done at that same edge.
  - The arbiter never acks a FU whose done is low.
  - At most one ack bit is high in any cycle.
- Broadcast latency:
  - 1 cycle: winner's fu_value, fu_rob_tag and fu_take_branch are registered on the ack edge.
  - cdb_valid=1 the following cycle.
- No-grant cycle:
  - cdb_valid <= 0.
  - cdb_value, cdb_rob_tag, cdb_take_branch hold their previous values (don't-care to consumers).
- Round-robin pointer update:
  - On a grant to FU g: rr_ptr <= (g+1) mod N_FU; wraps from N_FU-1 to 0.
  - No grant or squash: rr_ptr holds.
- squash at a posedge:
  - cdb_valid <= 0.
  - No ack is issued, so pending FUs keep done; FU-side flush clears them.
- grant_count:
  - Increments on each edge where a grant occurs.
  - Saturates at 16'hFFFF; no wrap.
- Fairness: with all FUs continuously done, each FU is granted exactly once every N_FU cycles.
- Back-to-back: the same FU may be granted on consecutive cycles only if no other FU is done.
- Simultaneous new done and ack on the same FU is FU-internal; the arbiter only sees the fu_done level.
- Reset asserted mid-broadcast: cdb_valid drops asynchronously and the in-flight result is lost.

Test Plan:
- Reset, then fu_done=4'b0000 for 3 cycles -> ack=0, cdb_valid=0, rr_ptr=0, grant_count=0.
- fu_done=4'b0100, fu_value[2]=32'h0000_00AA, fu_rob_tag[2]=5'd7, fu_take_branch[2]=1 -> ack=4'b0100 in the same cycle; next cycle cdb_valid=1, cdb_value=32'hAA, cdb_rob_tag=7, cdb_take_branch=1, grant_count=1.
- Hold fu_done=4'b1111 (model FU clearing ignored) for 8 cycles from reset -> ack sequence 0001,0010,0100,1000,0001,0010,0100,1000; cdb_rob_tag follows FU order 0,1,2,3,0,1,2,3.
- rr_ptr=3 with fu_done=4'b0011 -> ack=4'b0001 (wrap from 3 to 0); rr_ptr becomes 1.
- Grant cycle with squash=1 and fu_done=4'b0010 -> ack=0, next cycle cdb_valid=0, rr_ptr and grant_count unchanged.
- Assert reset asynchronously between edges while cdb_valid=1 -> cdb_valid=0 and ack=0 before the next posedge; after release, the first grant goes to the lowest-index done FU.
